// File: rtl/xgmii_tx_encap.sv
// XGMII transmit encapsulator: wraps snooped TLP words from the snoop FIFO
// in an Ethernet frame (preamble/SFD, 16-byte header, payload, pad, FCS,
// terminate) and drives the 64-bit XGMII TX lanes.
// state_q names the word currently on the XGMII outputs; each cycle the
// logic decides the next word, so the word registered at the end of a
// cycle in which a marker is popped is already the START word.
module xgmii_tx_encap #(
    parameter logic [15:0] ETHERTYPE = 16'h88B5,
    parameter int          MIN_BODY  = 60
) (
    input  logic        clk,
    input  logic        sys_rst_n,
    input  logic [71:0] dout,
    input  logic        empty,
    output logic        rd_en,
    input  logic [47:0] if_macaddr,
    input  logic [47:0] dest_macaddr,
    output logic [63:0] xgmii_txd,
    output logic [7:0]  xgmii_txc,
    output logic [31:0] tx_frames,
    output logic [15:0] tx_errors
);
    typedef enum logic [3:0] {
        IDLE, START, HDR0, HDR1, PAYLOAD, PAD, FCS, TERM, IFG, DISCARD
    } state_t;

    localparam logic [63:0] IDLE_W  = {8{8'h07}};
    localparam logic [63:0] START_W = 64'hD5555555555555FB;
    localparam logic [63:0] TERM_W  = 64'h07070707070707FD;
    localparam logic [63:0] ABORT_W = {8{8'hFE}};
    localparam logic [11:0] MIN_CNT = 12'(MIN_BODY);

    // Reflected CRC-32 over 8 bytes (or bytes 0-3 only when half is set).
    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [63:0] d,
                                            input logic half);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 64; i++) begin
            if (!(half && i >= 32)) begin
                if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
                else             r = r >> 1;
            end
        end
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [63:0] txd_q, txd_d;
    logic [7:0]  txc_q, txc_d;
    logic [31:0] crc_q, crc_d, c4;
    logic [11:0] cnt_q, cnt_d;
    logic        half_q, half_d;     // last payload word was a half word
    logic        fcs_q, fcs_d;       // FCS already placed in an emitted word
    logic        fd_pend_q, fd_pend_d;
    logic [31:0] frames_q;
    logic [15:0] errors_q;
    logic        run_q;
    logic        pop, tail, frame_inc, err_inc;
    logic        h_marker, h_filler, h_full, h_half, h_illegal;
    logic [63:0] hdr0, hdr1;

    assign h_marker  = dout[71:64] == 8'h10;
    assign h_filler  = dout[71:64] == 8'h00;
    assign h_full    = dout[71:64] == 8'hFF;
    assign h_half    = dout[71:64] == 8'h0F;
    assign h_illegal = !(h_marker || h_filler || h_full || h_half);

    assign hdr0 = {if_macaddr[39:32], if_macaddr[47:40],
                   dest_macaddr[7:0], dest_macaddr[15:8], dest_macaddr[23:16],
                   dest_macaddr[31:24], dest_macaddr[39:32], dest_macaddr[47:40]};
    assign hdr1 = {8'h00, 8'h00, ETHERTYPE[7:0], ETHERTYPE[15:8],
                   if_macaddr[7:0], if_macaddr[15:8], if_macaddr[23:16], if_macaddr[31:24]};

    // Next-word decision: what goes on the lanes next cycle, and whether the head is popped.
    always_comb begin
        state_d   = state_q;
        txd_d     = IDLE_W;
        txc_d     = 8'hFF;
        crc_d     = crc_q;
        cnt_d     = cnt_q;
        half_d    = half_q;
        fcs_d     = fcs_q;
        fd_pend_d = fd_pend_q;
        c4        = 32'h0;
        pop       = 1'b0;
        tail      = 1'b0;
        frame_inc = 1'b0;
        err_inc   = 1'b0;
        case (state_q)
            START: begin
                txd_d   = hdr0;
                txc_d   = 8'h00;
                crc_d   = crc_upd(crc_q, hdr0, 1'b0);
                state_d = HDR0;
            end
            HDR0: begin
                txd_d   = hdr1;
                txc_d   = 8'h00;
                crc_d   = crc_upd(crc_q, hdr1, 1'b0);
                cnt_d   = 12'd16;
                state_d = HDR1;
            end
            HDR1, PAYLOAD: begin
                if (empty || h_illegal || (half_q && (h_full || h_half))) begin
                    // Abort: error word now, terminate next, then flush to a marker.
                    txd_d     = ABORT_W;
                    state_d   = DISCARD;
                    fd_pend_d = 1'b1;
                    err_inc   = 1'b1;
                end else if (h_full || h_half) begin
                    pop     = 1'b1;
                    txc_d   = 8'h00;
                    half_d  = h_half;
                    state_d = PAYLOAD;
                    if (h_full) begin
                        txd_d = dout[63:0];
                        crc_d = crc_upd(crc_q, dout[63:0], 1'b0);
                        cnt_d = cnt_q + 12'd8;
                    end else if (cnt_q + 12'd4 >= MIN_CNT) begin
                        // A half word must be the last one, so the FCS rides in lanes 4-7.
                        c4    = crc_upd(crc_q, dout[63:0], 1'b1);
                        txd_d = {~c4, dout[31:0]};
                        cnt_d = cnt_q + 12'd4;
                        fcs_d = 1'b1;
                    end else begin
                        txd_d = {32'h0, dout[31:0]};
                        crc_d = crc_upd(crc_q, {32'h0, dout[31:0]}, 1'b0);
                        cnt_d = cnt_q + 12'd8;
                    end
                end else begin
                    // Filler or marker at head: previous word was the last one.
                    pop  = h_filler;
                    tail = 1'b1;
                end
            end
            PAD: tail = 1'b1;
            FCS, TERM: begin
                state_d   = IFG;
                frame_inc = 1'b1;
            end
            DISCARD: begin
                pop = !empty && !h_marker;
                if (fd_pend_q) begin
                    txd_d     = TERM_W;
                    fd_pend_d = 1'b0;
                end else if (!empty && h_marker) begin
                    state_d = IDLE;
                end
            end
            default: begin
                // IDLE and IFG: look for the next marker.
                state_d = IDLE;
                if (run_q && !empty) begin
                    pop = 1'b1;
                    if (h_marker) begin
                        txd_d   = START_W;
                        txc_d   = 8'h01;
                        crc_d   = 32'hFFFFFFFF;
                        half_d  = 1'b0;
                        fcs_d   = 1'b0;
                        state_d = START;
                    end else if (!h_filler) begin
                        err_inc = 1'b1;
                    end
                end
            end
        endcase
        if (tail) begin
            txc_d = 8'h00;
            if (fcs_q) begin
                txd_d   = TERM_W;
                txc_d   = 8'hFF;
                state_d = TERM;
            end else if (cnt_q + 12'd4 == MIN_CNT) begin
                c4      = crc_upd(crc_q, 64'h0, 1'b1);
                txd_d   = {~c4, 32'h0};
                cnt_d   = cnt_q + 12'd4;
                fcs_d   = 1'b1;
                state_d = PAD;
            end else if (cnt_q < MIN_CNT) begin
                txd_d   = 64'h0;
                crc_d   = crc_upd(crc_q, 64'h0, 1'b0);
                cnt_d   = cnt_q + 12'd8;
                state_d = PAD;
            end else begin
                txd_d   = {8'h07, 8'h07, 8'h07, 8'hFD, ~crc_q};
                txc_d   = 8'hF0;
                state_d = FCS;
            end
        end
    end

    assign rd_en     = pop && !empty;
    assign xgmii_txd = txd_q;
    assign xgmii_txc = txc_q;
    assign tx_frames = frames_q;
    assign tx_errors = errors_q;

    // State, output lanes, CRC/count and statistics registers.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            txd_q     <= IDLE_W;
            txc_q     <= 8'hFF;
            crc_q     <= 32'hFFFFFFFF;
            cnt_q     <= 12'd0;
            half_q    <= 1'b0;
            fcs_q     <= 1'b0;
            fd_pend_q <= 1'b0;
            frames_q  <= 32'd0;
            errors_q  <= 16'd0;
            run_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            txd_q     <= txd_d;
            txc_q     <= txc_d;
            crc_q     <= crc_d;
            cnt_q     <= cnt_d;
            half_q    <= half_d;
            fcs_q     <= fcs_d;
            fd_pend_q <= fd_pend_d;
            run_q     <= 1'b1;
            if (frame_inc) frames_q <= frames_q + 32'd1;
            if (err_inc && errors_q != 16'hFFFF) errors_q <= errors_q + 16'd1;
        end
    end
endmodule

// File: tb/tb_xgmii_tx_encap.sv
// Directed bench for xgmii_tx_encap: a queue models the FWFT snoop FIFO,
// expected lane words come from a byte-stream frame builder.
module tb_xgmii_tx_encap;
    localparam logic [47:0] SRC  = 48'h02_11_22_33_44_55;
    localparam logic [47:0] DST  = 48'h0A_BB_CC_DD_EE_FF;
    localparam logic [71:0] STW  = {8'h01, 64'hD5555555555555FB};
    localparam logic [71:0] IDW  = {8'hFF, 64'h0707070707070707};

    logic        clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [71:0] dout = 72'h0;
    logic        empty = 1'b1;
    logic        rd_en;
    logic [63:0] xgmii_txd;
    logic [7:0]  xgmii_txc;
    logic [31:0] tx_frames;
    logic [15:0] tx_errors;

    always #5 clk = ~clk;

    xgmii_tx_encap dut (
        .clk(clk), .sys_rst_n(sys_rst_n), .dout(dout), .empty(empty), .rd_en(rd_en),
        .if_macaddr(SRC), .dest_macaddr(DST), .xgmii_txd(xgmii_txd), .xgmii_txc(xgmii_txc),
        .tx_frames(tx_frames), .tx_errors(tx_errors)
    );

    typedef struct {
        int         nfull;
        bit         half;
        int         exp_words;  // START .. IFG inclusive
        logic [7:0] fd_txc;     // txc of the word carrying FD
    } vec_t;

    logic [71:0] fifo[$];
    logic [71:0] log_w[$];
    logic [71:0] pl_q[$];
    logic [71:0] exp_q[$];
    int cyc = 0, mark_cyc = -1, start_cyc = -1, rd_viol = 0;
    int pass_cnt = 0, chk_cnt = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic refresh();
        empty = (fifo.size() == 0);
        dout  = (fifo.size() != 0) ? fifo[0] : 72'h0;
    endtask

    task automatic tick();
        logic pop;
        #2;
        pop = rd_en;
        if (rd_en && empty) rd_viol++;
        if (pop && fifo.size() != 0 && fifo[0][71:64] == 8'h10 && mark_cyc < 0) mark_cyc = cyc;
        @(posedge clk);
        if (pop && fifo.size() != 0) void'(fifo.pop_front());
        cyc++;
        #1;
        refresh();
        log_w.push_back({xgmii_txc, xgmii_txd});
        if ({xgmii_txc, xgmii_txd} == STW && start_cyc < 0) start_cyc = cyc;
    endtask

    task automatic new_scenario();
        log_w.delete();
        mark_cyc  = -1;
        start_cyc = -1;
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    function automatic logic [71:0] mkw(input int r, input int j, input bit half);
        logic [63:0] d;
        d = {8'hA0 ^ 8'(r), 8'h50 ^ 8'(j), 48'h1234_5678_9ABC} ^ {56'h0, 8'(j * 3 + r)};
        return {half ? 8'h0F : 8'hFF, d};
    endfunction

    // Build expected lane words for the frame carrying pl_q.
    task automatic build_exp(input bit abort);
        logic [8:0]  b[$];
        logic [7:0]  body[$];
        logic [31:0] c;
        logic [63:0] d;
        logic [7:0]  t;
        exp_q.delete();
        b.push_back({1'b1, 8'hFB});
        repeat (6) b.push_back({1'b0, 8'h55});
        b.push_back({1'b0, 8'hD5});
        for (int i = 0; i < 6; i++) body.push_back(DST[47 - 8 * i -: 8]);
        for (int i = 0; i < 6; i++) body.push_back(SRC[47 - 8 * i -: 8]);
        body.push_back(8'h88); body.push_back(8'hB5); body.push_back(8'h00); body.push_back(8'h00);
        foreach (pl_q[w])
            for (int i = 0; i < ((pl_q[w][71:64] == 8'hFF) ? 8 : 4); i++)
                body.push_back(pl_q[w][8 * i +: 8]);
        if (abort) begin
            foreach (body[i]) b.push_back({1'b0, body[i]});
            repeat (8) b.push_back({1'b1, 8'hFE});
            b.push_back({1'b1, 8'hFD});
            repeat (7) b.push_back({1'b1, 8'h07});
        end else begin
            while (body.size() < 60) body.push_back(8'h00);
            c = 32'hFFFFFFFF;
            foreach (body[i]) begin
                c = crc_byte(c, body[i]);
                b.push_back({1'b0, body[i]});
            end
            c = ~c;
            for (int i = 0; i < 4; i++) b.push_back({1'b0, c[8 * i +: 8]});
            b.push_back({1'b1, 8'hFD});
            while (b.size() % 8 != 0) b.push_back({1'b1, 8'h07});
            repeat (8) b.push_back({1'b1, 8'h07});
        end
        for (int k = 0; k < b.size() / 8; k++) begin
            d = 64'h0;
            t = 8'h0;
            for (int i = 0; i < 8; i++) begin
                d[8 * i +: 8] = b[8 * k + i][7:0];
                t[i]          = b[8 * k + i][8];
            end
            exp_q.push_back({t, d});
        end
    endtask

    function automatic int find_start(input int from);
        for (int i = from; i < log_w.size(); i++) if (log_w[i] == STW) return i;
        return -1;
    endfunction

    task automatic cmp_frame(input string tag, input int s);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (s >= 0 && s + k < log_w.size()) begin
                check($sformatf("%s_w%0d", tag, k), log_w[s + k], exp_q[k]);
            end else begin
                chk_cnt++;
                $display("FAIL %s_w%0d: word not captured, want %h", tag, k, exp_q[k]);
            end
        end
    endtask

    // CRC register over data bytes after START up to FD, FCS included.
    function automatic logic [31:0] residue(input int s);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        if (s < 0) return 32'h0;
        for (int w = s + 1; w < log_w.size() && w < s + 24; w++)
            for (int i = 0; i < 8; i++) begin
                if (log_w[w][64 + i]) begin
                    if (log_w[w][8 * i +: 8] == 8'hFD) return c;
                end else begin
                    c = crc_byte(c, log_w[w][8 * i +: 8]);
                end
            end
        return 32'h0;
    endfunction

    task automatic push_frame(input bit tail_filler);
        fifo.push_back({8'h10, 64'h0});
        foreach (pl_q[i]) fifo.push_back(pl_q[i]);
        if (tail_filler) fifo.push_back({8'h00, 64'h0});
        refresh();
    endtask

    vec_t tbl[6];
    int   s, s2;

    initial begin
        tbl[0] = '{3, 1'b0, 11, 8'hFF};
        tbl[1] = '{8, 1'b0, 13, 8'hF0};
        tbl[2] = '{6, 1'b1, 12, 8'hFF};
        tbl[3] = '{5, 1'b1, 11, 8'hFF};
        tbl[4] = '{0, 1'b0, 11, 8'hFF};
        tbl[5] = '{1, 1'b1, 11, 8'hFF};

        // Reset held with traffic waiting at the FIFO head.
        pl_q.delete();
        for (int j = 0; j < 3; j++) pl_q.push_back(mkw(9, j, 1'b0));
        push_frame(1'b1);
        repeat (3) tick();
        check("rst_txd", {8'h0, xgmii_txd}, {8'h0, 64'h0707070707070707});
        check("rst_txc", {64'h0, xgmii_txc}, {64'h0, 8'hFF});
        check("rst_rd_en", {71'h0, rd_en}, 72'h0);
        check("rst_frames", {40'h0, tx_frames}, 72'h0);
        check("rst_errors", {56'h0, tx_errors}, 72'h0);
        fifo.delete();
        refresh();
        sys_rst_n = 1'b1;
        repeat (2) tick();

        // Table-driven clean frames.
        for (int r = 0; r < 6; r++) begin
            new_scenario();
            pl_q.delete();
            for (int j = 0; j < tbl[r].nfull; j++) pl_q.push_back(mkw(r, j, 1'b0));
            if (tbl[r].half) pl_q.push_back(mkw(r, 15, 1'b1));
            push_frame(1'b1);
            repeat (26) tick();
            build_exp(1'b0);
            s = find_start(0);
            check($sformatf("r%0d_latency", r), 72'(start_cyc - mark_cyc), 72'd1);
            check($sformatf("r%0d_len", r), 72'(exp_q.size()), 72'(tbl[r].exp_words));
            cmp_frame($sformatf("r%0d", r), s);
            if (s >= 0 && s + tbl[r].exp_words - 2 < log_w.size())
                check($sformatf("r%0d_fd_txc", r), {64'h0, log_w[s + tbl[r].exp_words - 2][71:64]},
                      {64'h0, tbl[r].fd_txc});
            else check($sformatf("r%0d_fd_txc", r), 72'h0, {64'h0, tbl[r].fd_txc});
            check($sformatf("r%0d_residue", r), {40'h0, residue(s)}, {40'h0, 32'hDEBB20E3});
            check($sformatf("r%0d_frames", r), {40'h0, tx_frames}, 72'(r + 1));
            check($sformatf("r%0d_errors", r), {56'h0, tx_errors}, 72'h0);
        end

        // Underrun mid-payload: FE word, terminate, then discard stale words.
        new_scenario();
        pl_q.delete();
        for (int j = 0; j < 2; j++) pl_q.push_back(mkw(20, j, 1'b0));
        push_frame(1'b0);
        repeat (14) tick();
        build_exp(1'b1);
        cmp_frame("abort", find_start(0));
        check("abort_errors", {56'h0, tx_errors}, 72'd1);
        check("abort_frames", {40'h0, tx_frames}, 72'd6);
        new_scenario();
        fifo.push_back(mkw(21, 0, 1'b0));
        fifo.push_back(mkw(21, 1, 1'b1));
        fifo.push_back({8'h00, 64'h0});
        fifo.push_back(mkw(21, 2, 1'b0));
        pl_q.delete();
        for (int j = 0; j < 2; j++) pl_q.push_back(mkw(22, j, 1'b0));
        push_frame(1'b1);
        repeat (30) tick();
        build_exp(1'b0);
        s = find_start(0);
        cmp_frame("recover", s);
        check("recover_residue", {40'h0, residue(s)}, {40'h0, 32'hDEBB20E3});
        check("recover_frames", {40'h0, tx_frames}, 72'd7);
        check("recover_errors", {56'h0, tx_errors}, 72'd1);
        check("recover_fifo_drained", 72'(fifo.size()), 72'd0);

        // Two frames separated only by a marker.
        new_scenario();
        pl_q.delete();
        for (int j = 0; j < 3; j++) pl_q.push_back(mkw(30, j, 1'b0));
        push_frame(1'b0);
        pl_q.delete();
        for (int j = 0; j < 2; j++) pl_q.push_back(mkw(31, j, 1'b0));
        push_frame(1'b1);
        repeat (34) tick();
        s = find_start(0);
        pl_q.delete();
        for (int j = 0; j < 3; j++) pl_q.push_back(mkw(30, j, 1'b0));
        build_exp(1'b0);
        cmp_frame("b2b_a", s);
        s2 = (s >= 0) ? s + exp_q.size() : -1;
        check("b2b_next_start", (s2 >= 0 && s2 < log_w.size()) ? log_w[s2] : IDW, STW);
        pl_q.delete();
        for (int j = 0; j < 2; j++) pl_q.push_back(mkw(31, j, 1'b0));
        build_exp(1'b0);
        cmp_frame("b2b_b", s2);
        check("b2b_residue_a", {40'h0, residue(s)}, {40'h0, 32'hDEBB20E3});
        check("b2b_residue_b", {40'h0, residue(s2)}, {40'h0, 32'hDEBB20E3});
        check("b2b_frames", {40'h0, tx_frames}, 72'd9);

        // Reset mid-frame: outputs go idle at once, no clock edge needed.
        new_scenario();
        pl_q.delete();
        for (int j = 0; j < 8; j++) pl_q.push_back(mkw(40, j, 1'b0));
        push_frame(1'b1);
        repeat (7) tick();
        check("mid_busy", {8'h0, xgmii_txd} == {8'h0, 64'h0707070707070707} ? 72'd1 : 72'd0, 72'd0);
        sys_rst_n = 1'b0;
        #1;
        check("midrst_txd", {xgmii_txc, xgmii_txd}, IDW);
        check("midrst_rd_en", {71'h0, rd_en}, 72'h0);
        check("midrst_frames", {40'h0, tx_frames}, 72'h0);
        check("rd_en_while_empty", 72'(rd_viol), 72'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
